// File: rtl/ahb_arbiter_n.sv
// ============================================================================
// ahb_arbiter_n : N-master AHB bus arbiter with lock hold and registered grant.
// Optional round-robin policy via `define AHB_ARBITER_N_RR_EN (else fixed).
// Revision 1.0
// ============================================================================
`default_nettype none

module ahb_arbiter_n #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
      $fatal(1, "ahb_arbiter_n: NUM_MASTERS must be in 2..16");
    end
    if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default_master
      $fatal(1, "ahb_arbiter_n: DEFAULT_MASTER must be < NUM_MASTERS");
    end
  endgenerate

  localparam logic [3:0]             DEFAULT_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [3:0]             LAST_IDX      = 4'(NUM_MASTERS - 1);

  logic [3:0] owner;
  logic       owner_lock;
  logic [3:0] winner;
  logic       any_req;

  // Encode the one-hot grant; upper hmaster bits stay zero by construction.
  always_comb begin
    owner      = 4'd0;
    owner_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) owner = owner | 4'(i);
      owner_lock = owner_lock | (hgrant[i] & hlock[i]);
    end
  end

  assign any_req   = |hbusreq;
  assign hmastlock = hreset ? hlock[DEFAULT_MASTER] : owner_lock;

`ifdef AHB_ARBITER_N_RR_EN
  logic [3:0] ptr;
  logic [3:0] hi_win;
  logic [3:0] lo_win;
  logic       hi_found;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_win   = DEFAULT_IDX;
    lo_win   = DEFAULT_IDX;
    hi_found = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (hbusreq[i]) begin
        lo_win = 4'(i);
        if (4'(i) >= ptr) begin
          hi_win   = 4'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ptr <= (DEFAULT_IDX == LAST_IDX) ? 4'd0 : DEFAULT_IDX + 4'd1;
    end else if (hready && !owner_lock && any_req && (winner != owner)) begin
      ptr <= (winner == LAST_IDX) ? 4'd0 : winner + 4'd1;
    end
  end
`else
  always_comb begin
    winner = DEFAULT_IDX;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (hbusreq[i]) winner = 4'(i);
    end
  end
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant  <= DEFAULT_GRANT;
      hmaster <= DEFAULT_IDX;
    end else if (hready) begin
      hmaster <= owner;
      if (!owner_lock) begin
        hgrant <= any_req ? (NUM_MASTERS'(1) << winner) : DEFAULT_GRANT;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter_n.sv
// Bench for ahb_arbiter_n (4 masters, default 0): directed steps plus random
// traffic, checked against a behavioural model through a scoreboard queue.
`default_nettype none

module tb_ahb_arbiter_n;
  localparam int N   = 4;
  localparam int DEF = 0;

  logic       clk = 1'b0;
  logic       rst, rdy, mlock;
  logic [3:0] req, lock, grant, master;

  always #5 clk = ~clk;

  ahb_arbiter_n #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .hclk(clk), .hreset(rst), .hbusreq(req), .hlock(lock), .hready(rdy),
    .hgrant(grant), .hmaster(master), .hmastlock(mlock)
  );

  typedef struct {
    logic [3:0] grant;
    logic [3:0] master;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miscompares = 0;
  int   m_g = DEF;
  int   m_master = DEF;
  int   m_ptr = (DEF + 1) % N;

  function automatic int pick(logic [3:0] r, int p);
`ifdef AHB_ARBITER_N_RR_EN
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`else
    for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
    return DEF;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s_rst, input logic s_rdy,
                      input logic [3:0] s_req, input logic [3:0] s_lock);
    exp_t e;
    int   ng, nm, np;
    rst = s_rst; rdy = s_rdy; req = s_req; lock = s_lock;
    ng = m_g; nm = m_master; np = m_ptr;
    if (s_rst) begin
      ng = DEF; nm = DEF; np = (DEF + 1) % N;
    end else if (s_rdy) begin
      nm = m_g;
      if (!s_lock[m_g]) begin
        if (s_req == 4'd0) ng = DEF;
        else begin
          ng = pick(s_req, m_ptr);
          if (ng != m_g) np = (ng + 1) % N;
        end
      end
    end
    e.grant  = 4'(1 << ng);
    e.master = 4'(nm);
    sb.push_back(e);
    @(posedge clk);
    #1;
    m_g = ng; m_master = nm; m_ptr = np;
    e = sb.pop_front();
    check("hgrant", 32'(grant), 32'(e.grant));
    check("hmaster", 32'(master), 32'(e.master));
    check("onehot", 32'($onehot(grant)), 32'd1);
    check("hmastlock", 32'(mlock), 32'(s_rst ? s_lock[DEF] : s_lock[m_g]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rr_seq [5];
    rst = 1'b1; rdy = 1'b1; req = 4'd0; lock = 4'd0;

    // Reset then idle
    step(1, 1, 4'b0000, 4'b0000);
    step(1, 1, 4'b0000, 4'b0000);
    check("reset_grant", 32'(grant), 32'h1);
    check("reset_master", 32'(master), 32'h0);
    step(0, 1, 4'b0000, 4'b0000);
    check("idle_grant", 32'(grant), 32'h1);

    // Sole requester handover
    step(0, 1, 4'b0100, 4'b0000);
    check("handover_grant", 32'(grant), 32'h4);
    check("handover_master_lag", 32'(master), 32'h0);
    step(0, 1, 4'b0100, 4'b0000);
    check("handover_master", 32'(master), 32'h2);
    step(0, 1, 4'b0000, 4'b0000);
    step(0, 1, 4'b0000, 4'b0000);
    check("back_to_default", 32'(grant), 32'h1);

    // Handover stalled by hready=0
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b0100, 4'b0000);
      check("stall_grant_hold", 32'(grant), 32'h1);
    end
    step(0, 1, 4'b0100, 4'b0000);
    check("stall_grant", 32'(grant), 32'h4);
    step(0, 1, 4'b0100, 4'b0000);
    check("stall_master", 32'(master), 32'h2);

    // Locked ownership by master 1
    step(0, 1, 4'b0010, 4'b0000);
    check("lock_acquire", 32'(grant), 32'h2);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'b1111, 4'b0010);
      check("lock_hold_grant", 32'(grant), 32'h2);
      check("lock_mastlock", 32'(mlock), 32'h1);
    end
    step(0, 1, 4'b1111, 4'b0000);
`ifdef AHB_ARBITER_N_RR_EN
    check("lock_release", 32'(grant), 32'h4);
`else
    check("lock_release", 32'(grant), 32'h1);
`endif

    // Reset overrides a lock hold
    step(0, 1, 4'b1000, 4'b0000);
    step(0, 1, 4'b1111, 4'b1000);
    check("relock_grant", 32'(grant), 32'h8);
    step(1, 1, 4'b1111, 4'b1111);
    check("reset_midlock_grant", 32'(grant), 32'h1);
    check("reset_midlock_master", 32'(master), 32'h0);

    // Policy-specific arbitration
`ifdef AHB_ARBITER_N_RR_EN
    rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001; rr_seq[4] = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'b1111, 4'b0000);
      check("rr_rotate", 32'(grant), 32'(rr_seq[i]));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'b1000, 4'b0000);
      check("rr_sole_owner", 32'(grant), 32'h8);
    end
`else
    rr_seq[0] = 4'b0000;
    step(0, 1, 4'b1100, rr_seq[0]);
    check("fixed_1100", 32'(grant), 32'h4);
    step(0, 1, 4'b1101, rr_seq[0]);
    check("fixed_preempt", 32'(grant), 32'h1);
`endif

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] r, l;
      r = 4'($urandom);
      l = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), r, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_arbiter_n.md
AHB_ARBITER_N -- requirements
Module: ahb_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of requesting masters; legal range 2..16.
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0: index granted when no master requests; must be < NUM_MASTERS.
REQ-003 SHALL have port hclk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port hreset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port hbusreq, input, NUM_MASTERS bits: bus request, bit i from master i.
REQ-006 SHALL have port hlock, input, NUM_MASTERS bits: locked-transfer request, bit i from master i.
REQ-007 SHALL have port hready, input, 1 bit: transfer-complete from the selected slave.
REQ-008 SHALL have port hgrant, output, NUM_MASTERS bits: registered one-hot grant.
REQ-009 SHALL have port hmaster, output, 4 bits: index of the master owning the address phase.
REQ-010 SHALL have port hmastlock, output, 1 bit: current transfer is locked.

Function
REQ-011 hgrant SHALL be exactly one-hot in every cycle after reset; never zero, never multi-hot.
REQ-012 Arbitration SHALL be evaluated only on cycles with hready=1; with hready=0, hgrant, hmaster and the priority pointer SHALL hold.
REQ-013 Grant owner G = index of the set hgrant bit; on an hready=1 edge, if hlock[G]=1, hgrant SHALL hold regardless of other requests (lock hold).
REQ-014 Otherwise, on an hready=1 edge, hgrant SHALL move to the winner among set hbusreq bits per the selected policy (REQ-021/022).
REQ-015 If no hbusreq bit is set, hgrant SHALL move to DEFAULT_MASTER on the next hready=1 edge.
REQ-016 On each hready=1 edge, hmaster SHALL load G as it was before that edge; hmaster therefore lags a grant change by exactly one hready=1 edge.
REQ-017 hmastlock SHALL equal hlock[G], combinationally, in every cycle.
REQ-018 hbusreq bits at index >= NUM_MASTERS do not exist; hmaster upper bits beyond clog2(NUM_MASTERS) SHALL read 0.
REQ-019 hlock[i] with hbusreq[i]=0 and i != G SHALL have no effect on arbitration.
REQ-020 Grant latency: a sole requester SHALL see hgrant set on the first hready=1 edge after hbusreq rises, and hmaster equal to its index after the next hready=1 edge.
REQ-021 Fixed-priority policy: the lowest-indexed requester wins; the owner SHALL be preempted by a lower index at the next unlocked hready=1 edge.
REQ-022 Round-robin policy: the search SHALL start at pointer P and wrap from NUM_MASTERS-1 to 0; the first requester found wins, and P SHALL load (winner+1) mod NUM_MASTERS when the grant changes.
REQ-023 Round-robin: if the owner is the only requester, it SHALL keep the grant and P SHALL hold.

Reset
REQ-024 With hreset=1 at a rising hclk edge: hgrant SHALL be one-hot at DEFAULT_MASTER, hmaster SHALL be DEFAULT_MASTER, and P SHALL be (DEFAULT_MASTER+1) mod NUM_MASTERS.
REQ-025 hreset SHALL override hready and any lock hold, including mid-locked-sequence.
REQ-026 hmastlock SHALL reflect hlock[DEFAULT_MASTER] during reset.

Configuration
REQ-027 Macro AHB_ARBITER_N_RR_EN defined: the round-robin policy (REQ-022/023) SHALL be compiled in and REQ-021 SHALL not apply.
REQ-028 Macro AHB_ARBITER_N_RR_EN undefined: the fixed-priority policy (REQ-021) SHALL apply and no pointer register SHALL exist.
REQ-029 Parameter-range violations (REQ-001, REQ-002) SHALL trigger an elaboration-time fatal error.

Verification (NUM_MASTERS=4, DEFAULT_MASTER=0, hready=1 unless stated)
REQ-030 Reset then idle: hreset=1 for 2 cycles, hbusreq=0 -> hgrant=4'b0001, hmaster=0, hmastlock=hlock[0] in every cycle.
REQ-031 Handover: hbusreq=4'b0100 from cycle 0 -> hgrant=4'b0100 after edge 1 and hmaster=2 after edge 2; hready=0 for 3 cycles at edge 1 -> both transitions delayed by 3 cycles.
REQ-032 Lock: master 1 granted with hlock[1]=1 for 5 cycles while hbusreq=4'b1111 -> hgrant=4'b0010 and hmastlock=1 throughout; grant moves on the first hready=1 edge after hlock[1] drops.
REQ-033 Fixed priority (macro off): hbusreq=4'b1100, then 4'b1101 -> grant 4'b0100, then 4'b0001 on the next edge.
REQ-034 Round-robin (macro on): hbusreq=4'b1111 held -> grant sequence 1,2,3,0,1 on successive edges; with 4'b1000 held -> grant stays 4'b1000.
REQ-035 Random stimulus for 10k cycles with a scoreboard -> REQ-011, REQ-016 and REQ-017 hold on every cycle, and reset asserted mid-lock recovers per REQ-024.
